// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for CPU pipeline stage registers: entry layout,
// bubble instruction and the elastic-stage occupancy encoding.
package cpu_pipe_pkg;

    localparam int PIPE_PC_W  = 32;
    localparam int PIPE_INS_W = 32;

    localparam logic [PIPE_INS_W-1:0] NOP_INSN_DEF = 32'h0000_0000;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef struct packed {
        logic [PIPE_PC_W-1:0]  pc;
        logic [PIPE_INS_W-1:0] ins;
    } stage_entry_t;

    function automatic logic state_has_entry(input logic [1:0] st);
        return (st != ST_EMPTY);
    endfunction

    function automatic logic state_is_full(input logic [1:0] st);
        return (st == ST_FULL);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;

    // Next count: clear, saturating increment, or hold
    always_comb begin
        w_count_nxt = r_count;
        if (clr) begin
            w_count_nxt = {CNT_W{1'b0}};
        end else if (inc && (r_count != CNT_MAX)) begin
            w_count_nxt = r_count + CNT_ONE;
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= {CNT_W{1'b0}};
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic {pc, ins} pipeline stage with a two-entry skid buffer, so
// in_ready depends only on state while throughput stays at one entry/cycle.
module pipe_stage_skid
    import cpu_pipe_pkg::*;
#(
    parameter int               PC_W     = 32,
    parameter int               INS_W    = 32,
    parameter logic [INS_W-1:0] NOP_INSN = {INS_W{1'b0}},
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PC_W-1:0]  in_pc,
    input  logic [INS_W-1:0] in_ins,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [INS_W-1:0] out_ins,
    input  logic             clr_stat,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [INS_W-1:0] ins;
    } entry_t;

    localparam entry_t BUBBLE = '{pc: {PC_W{1'b0}}, ins: NOP_INSN};

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    entry_t     r_main;
    entry_t     r_skid;
    entry_t     w_main_nxt;
    entry_t     w_skid_nxt;
    entry_t     w_in_entry;
    logic       w_in_fire;
    logic       w_out_fire;
    logic       w_stall;

    assign w_in_entry = '{pc: in_pc, ins: in_ins};

    assign in_ready  = !state_is_full(r_state);
    assign out_valid = state_has_entry(r_state);

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign w_stall    = out_valid & !out_ready & !flush;

    // Occupancy transitions; flush discards everything including an accepted input
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = BUBBLE;
            w_skid_nxt  = BUBBLE;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = w_in_entry;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = w_in_entry;
                    end else if (w_in_fire) begin
                        // Head is blocked: park the newcomer behind it
                        w_state_nxt = ST_FULL;
                        w_skid_nxt  = w_in_entry;
                    end else if (w_out_fire) begin
                        w_state_nxt = ST_EMPTY;
                    end else begin
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        w_state_nxt = ST_ONE;
                        w_main_nxt  = r_skid;
                    end else begin
                        w_state_nxt = ST_FULL;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                    w_main_nxt  = BUBBLE;
                    w_skid_nxt  = BUBBLE;
                end
            endcase
        end
    end

    // State and entry registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_main  <= BUBBLE;
            r_skid  <= BUBBLE;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
            r_skid  <= w_skid_nxt;
        end
    end

    // A drained head keeps its stale ins, so the bubble is forced at the output
    assign out_pc  = r_main.pc;
    assign out_ins = out_valid ? r_main.ins : NOP_INSN;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall),
        .clr   (clr_stat),
        .count (stall_cnt)
    );

endmodule
